// File: rtl/ghost_catch_arbiter.sv
// Decides on each movement tick whether a ghost has caught Pac-Man; owns lives and freeze/respawn/game-over sequencing.
// Latency: a catch sampled on a tick shows up (state/play_en/hit_id/lives) on the following clk; all outputs registered.
// Backpressure: none; play_en gates the movers, respawn is a one-cycle reload pulse, start is honoured only in IDLE/OVER.
module ghost_catch_arbiter #(
    parameter int LIVES_INIT   = 3,
    parameter int HIT_DIST     = 12,
    parameter int FREEZE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] pac_x,
    input  logic [8:0] pac_y,
    input  logic [9:0] g0_x,
    input  logic [9:0] g1_x,
    input  logic [9:0] g2_x,
    input  logic [8:0] g0_y,
    input  logic [8:0] g1_y,
    input  logic [8:0] g2_y,
    output logic       play_en,
    output logic       respawn,
    output logic [1:0] lives,
    output logic [1:0] hit_id,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_HIT     = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam int          CW          = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;
    localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_TICKS - 1);
    localparam logic [1:0]  LIVES_LOAD  = 2'(LIVES_INIT);
    localparam logic [31:0] HIT_LIM     = 32'(HIT_DIST);

    state_t          cur, nxt;
    logic [1:0]      lives_n, hit_id_n;
    logic [CW-1:0]   cnt, cnt_n;

    logic [9:0] gx [3];
    logic [8:0] gy [3];
    logic [9:0] dx [3];
    logic [8:0] dy [3];
    logic [2:0] contact;
    logic [1:0] first_hit;

    assign gx[0] = g0_x;
    assign gx[1] = g1_x;
    assign gx[2] = g2_x;
    assign gy[0] = g0_y;
    assign gy[1] = g1_y;
    assign gy[2] = g2_y;

    // Subtract smaller from larger so distances never wrap.
    for (genvar i = 0; i < 3; i++) begin : g_contact
        assign dx[i]      = (pac_x >= gx[i]) ? (pac_x - gx[i]) : (gx[i] - pac_x);
        assign dy[i]      = (pac_y >= gy[i]) ? (pac_y - gy[i]) : (gy[i] - pac_y);
        assign contact[i] = (32'(dx[i]) < HIT_LIM) && (32'(dy[i]) < HIT_LIM);
    end

    always_comb begin
        first_hit = 2'd3;
        if (contact[2]) first_hit = 2'd2;
        if (contact[1]) first_hit = 2'd1;
        if (contact[0]) first_hit = 2'd0;
    end

    always_comb begin
        nxt      = cur;
        lives_n  = lives;
        hit_id_n = hit_id;
        cnt_n    = cnt;
        case (cur)
            S_IDLE: begin
                if (start) begin
                    lives_n = LIVES_LOAD;
                    nxt     = S_RESPAWN;
                end
            end
            S_PLAY: begin
                if (tick && (contact != 3'b000)) begin
                    hit_id_n = first_hit;
                    lives_n  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    cnt_n    = FREEZE_LAST;
                    nxt      = S_HIT;
                end
            end
            S_HIT: begin
                if (tick) begin
                    if (cnt == '0) begin
                        nxt = (lives == 2'd0) ? S_OVER : S_RESPAWN;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            S_RESPAWN: begin
                hit_id_n = 2'd3;
                nxt      = S_PLAY;
            end
            S_OVER: begin
                if (start) begin
                    lives_n = LIVES_LOAD;
                    nxt     = S_RESPAWN;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Flag outputs are registered copies of the next state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_IDLE;
            lives     <= LIVES_LOAD;
            hit_id    <= 2'd3;
            cnt       <= '0;
            play_en   <= 1'b0;
            respawn   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            cur       <= nxt;
            lives     <= lives_n;
            hit_id    <= hit_id_n;
            cnt       <= cnt_n;
            play_en   <= (nxt == S_PLAY);
            respawn   <= (nxt == S_RESPAWN);
            game_over <= (nxt == S_OVER);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_ghost_catch_arbiter.sv
// Bench for ghost_catch_arbiter: vector table, corner-case sequences and a randomized run against a reference model.
module tb_ghost_catch_arbiter;

    localparam int LI = 3;
    localparam int HD = 12;
    localparam int FT = 60;
    localparam int P_IDLE = 0, P_PLAY = 1, P_HIT = 2, P_RESP = 3, P_OVER = 4;
    localparam int FX = 900, FY = 50;

    logic       clk = 1'b0;
    logic       rst, tick, start;
    logic [9:0] pac_x, g0_x, g1_x, g2_x;
    logic [8:0] pac_y, g0_y, g1_y, g2_y;
    logic       play_en, respawn, game_over;
    logic [1:0] lives, hit_id;
    logic [2:0] state;

    ghost_catch_arbiter #(.LIVES_INIT(LI), .HIT_DIST(HD), .FREEZE_TICKS(FT)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .pac_x(pac_x), .pac_y(pac_y),
        .g0_x(g0_x), .g1_x(g1_x), .g2_x(g2_x),
        .g0_y(g0_y), .g1_y(g1_y), .g2_y(g2_y),
        .play_en(play_en), .respawn(respawn), .lives(lives),
        .hit_id(hit_id), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_phase, m_lives, m_hit, m_left;
    bit seen_resp;

    typedef struct {
        int px, py, x0, y0, x1, y1, x2, y2;
        bit tk;
        int hit;
    } vec_t;
    vec_t vt [10];

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit near(int px, int py, int gx, int gy);
        return (iabs(px - gx) < HD) && (iabs(py - gy) < HD);
    endfunction

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_lives = LI; m_hit = 3; m_left = 0;
    endtask

    // Game rules: a catch costs a life and freezes play for FT ticks, then respawn or game over.
    task automatic model_step();
        int px, py, who;
        if (rst) begin
            model_reset();
            return;
        end
        px = int'(pac_x); py = int'(pac_y);
        case (m_phase)
            P_IDLE, P_OVER: if (start) begin m_lives = LI; m_phase = P_RESP; end
            P_PLAY: if (tick) begin
                who = 3;
                if (near(px, py, int'(g2_x), int'(g2_y))) who = 2;
                if (near(px, py, int'(g1_x), int'(g1_y))) who = 1;
                if (near(px, py, int'(g0_x), int'(g0_y))) who = 0;
                if (who != 3) begin
                    m_hit = who;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_left = FT;
                    m_phase = P_HIT;
                end
            end
            P_HIT: if (tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = (m_lives == 0) ? P_OVER : P_RESP;
            end
            P_RESP: begin m_hit = 3; m_phase = P_PLAY; end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        seen_resp = seen_resp | respawn;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(string nm);
        chk({nm, ".state"}, int'(state), m_phase);
        chk({nm, ".lives"}, int'(lives), m_lives);
        chk({nm, ".hit_id"}, int'(hit_id), m_hit);
        chk({nm, ".flags"}, int'({play_en, respawn, game_over}),
            int'({m_phase == P_PLAY, m_phase == P_RESP, m_phase == P_OVER}));
    endtask

    task automatic place(int px, int py, int x0, int y0, int x1, int y1, int x2, int y2);
        pac_x = 10'(px); pac_y = 9'(py);
        g0_x = 10'(x0); g0_y = 9'(y0);
        g1_x = 10'(x1); g1_y = 9'(y1);
        g2_x = 10'(x2); g2_y = 9'(y2);
    endtask

    task automatic far();
        place(100, 100, FX, FY, FX, FY, FX, FY);
    endtask

    task automatic do_restart();
        rst = 1'b1; cycle(); rst = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
    endtask

    task automatic catch_g0();
        place(100, 100, 100, 100, FX, FY, FX, FY);
        tick = 1'b1; cycle(); tick = 1'b0;
        far();
    endtask

    task automatic dwell(int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; cycle(); tick = 1'b0; cycle();
        end
    endtask

    initial begin
        vt[0] = '{100, 100, FX, FY, 111, 89, FX, FY, 1'b1, 1};
        vt[1] = '{100, 100, FX, FY, 112, 100, FX, FY, 1'b1, 3};
        vt[2] = '{5, 5, 0, 0, FX, FY, 8, 1, 1'b1, 0};
        vt[3] = '{0, 0, 1023, 511, FX, FY, FX, FY, 1'b1, 3};
        vt[4] = '{500, 300, FX, FY, FX, FY, 489, 311, 1'b1, 2};
        vt[5] = '{100, 100, FX, FY, 100, 112, FX, FY, 1'b1, 3};
        vt[6] = '{100, 100, 95, 95, 100, 100, 110, 110, 1'b1, 0};
        vt[7] = '{100, 100, FX, FY, 101, 99, 90, 90, 1'b1, 1};
        vt[8] = '{100, 100, 100, 100, FX, FY, FX, FY, 1'b0, 3};
        vt[9] = '{1023, 511, 1012, 500, FX, FY, FX, FY, 1'b1, 0};

        rst = 1'b1; tick = 1'b0; start = 1'b0; seen_resp = 1'b0;
        far(); model_reset();
        cycle(); cycle();
        rst = 1'b0;
        chk("reset.state", int'(state), P_IDLE);
        chk("reset.lives", int'(lives), 3);
        chk("reset.hit_id", int'(hit_id), 3);
        chk("reset.flags", int'({play_en, respawn, game_over}), 0);

        tick = 1'b1; cycle(); tick = 1'b0;
        chk("idle_tick.state", int'(state), P_IDLE);
        start = 1'b1; cycle(); start = 1'b0;
        chk("start.state", int'(state), P_RESP);
        chk("start.respawn", int'(respawn), 1);
        cycle();
        chk("start.play_state", int'(state), P_PLAY);
        chk("start.play_en", int'(play_en), 1);
        chk("start.lives", int'(lives), 3);
        chk("start.hit_id", int'(hit_id), 3);

        foreach (vt[i]) begin
            do_restart();
            place(vt[i].px, vt[i].py, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].x2, vt[i].y2);
            tick = vt[i].tk; cycle(); tick = 1'b0;
            chk($sformatf("vec%0d.state", i), int'(state), (vt[i].hit == 3) ? P_PLAY : P_HIT);
            chk($sformatf("vec%0d.hit_id", i), int'(hit_id), vt[i].hit);
            chk($sformatf("vec%0d.lives", i), int'(lives), (vt[i].hit == 3) ? 3 : 2);
            chk($sformatf("vec%0d.play_en", i), int'(play_en), (vt[i].hit == 3) ? 1 : 0);
        end

        // Freeze dwell: ticks 1..59 stay in HIT, tick 60 gives a one-cycle respawn.
        do_restart();
        catch_g0();
        chk("dwell.catch", int'(state), P_HIT);
        for (int k = 1; k < FT; k++) begin
            tick = 1'b1; cycle(); tick = 1'b0; cycle();
            chk($sformatf("dwell.t%0d", k), int'({state, hit_id}), int'({3'(P_HIT), 2'd0}));
        end
        tick = 1'b1; cycle(); tick = 1'b0;
        chk("dwell.resp_state", int'(state), P_RESP);
        chk("dwell.resp_pulse", int'(respawn), 1);
        cycle();
        chk("dwell.play", int'({state, play_en, respawn}), int'({3'(P_PLAY), 1'b1, 1'b0}));
        chk("dwell.lives", int'(lives), 2);
        chk("dwell.hit_id", int'(hit_id), 3);

        // Three catches run out of lives.
        do_restart();
        catch_g0(); dwell(FT);
        chk("over.c1", int'({state, lives}), int'({3'(P_PLAY), 2'd2}));
        catch_g0(); dwell(FT);
        chk("over.c2", int'({state, lives}), int'({3'(P_PLAY), 2'd1}));
        seen_resp = 1'b0;
        catch_g0(); dwell(FT);
        chk("over.state", int'(state), P_OVER);
        chk("over.game_over", int'(game_over), 1);
        chk("over.lives", int'(lives), 0);
        chk("over.no_respawn", int'(seen_resp), 0);
        chk("over.hit_id", int'(hit_id), 0);
        start = 1'b1; tick = 1'b1; cycle(); start = 1'b0; tick = 1'b0;
        chk("restart.state", int'(state), P_RESP);
        chk("restart.lives", int'(lives), 3);
        chk("restart.game_over", int'(game_over), 0);

        // Reset in the middle of the freeze (counter at 30).
        do_restart();
        catch_g0(); dwell(29);
        chk("midhit.state", int'(state), P_HIT);
        rst = 1'b1; #1;
        chk("midhit.rst_state", int'(state), P_IDLE);
        chk("midhit.rst_lives", int'(lives), 3);
        chk("midhit.rst_hit", int'(hit_id), 3);
        chk("midhit.rst_play", int'(play_en), 0);
        cycle(); rst = 1'b0; cycle();
        chk("midhit.after", int'({state, respawn}), int'({3'(P_IDLE), 1'b0}));
        tick = 1'b1; cycle(); tick = 1'b0;
        chk("midhit.idle_tick", int'({state, lives, hit_id}), int'({3'(P_IDLE), 2'd3, 2'd3}));

        // Reset during the respawn cycle kills the pulse.
        start = 1'b1; cycle(); start = 1'b0;
        chk("midresp.pulse", int'(respawn), 1);
        rst = 1'b1; #1;
        chk("midresp.rst", int'({state, respawn}), int'({3'(P_IDLE), 1'b0}));
        cycle(); rst = 1'b0; cycle();
        chk("midresp.after", int'({state, respawn, play_en}), int'({3'(P_IDLE), 1'b0, 1'b0}));
        chk_model("hand_end");

        // Randomized play against the model.
        do_restart();
        for (int n = 0; n < 4000 && failures < 50; n++) begin
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int px, py, gxv[3], gyv[3];
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 511);
                for (int g = 0; g < 3; g++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        gxv[g] = clampi(px + $urandom_range(0, 28) - 14, 1023);
                        gyv[g] = clampi(py + $urandom_range(0, 28) - 14, 511);
                    end else begin
                        gxv[g] = $urandom_range(0, 1023);
                        gyv[g] = $urandom_range(0, 511);
                    end
                end
                place(px, py, gxv[0], gyv[0], gxv[1], gyv[1], gxv[2], gyv[2]);
            end
            cycle();
            chk_model($sformatf("rand%0d", n));
        end
        rst = 1'b0; tick = 1'b0; start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ghost_catch_arbiter.md
Name: ghost_catch_arbiter

Overview:
- Sits downstream of the three ghost movers and the Pac-Man mover.
- Consumes every sprite's pixel position and decides, on each movement tick, whether a ghost has caught Pac-Man.
- Owns the lives counter and the freeze/respawn/game-over sequencing.
- Drives play_en (gates all movers), respawn (reloads start positions) and game_over (to the display/score logic).

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on start; must be 1..3.
- HIT_DIST, 12, contact when |dx| < HIT_DIST and |dy| < HIT_DIST, in pixels.
- FREEZE_TICKS, 60, ticks spent frozen after a catch; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle movement strobe; same rate the movers step at.
- start  in  1  level; starts or restarts a game.
- pac_x  in  10  Pac-Man x position.
- pac_y  in  9  Pac-Man y position.
- g0_x, g1_x, g2_x  in  10 each  ghost x positions.
- g0_y, g1_y, g2_y  in  9 each  ghost y positions.
- play_en  out  1  high only in PLAY; movers advance only when high.
- respawn  out  1  one-cycle pulse; movers reload start positions.
- lives  out  2  remaining lives.
- hit_id  out  2  index of the catching ghost; 3 = none.
- game_over  out  1  high in OVER.
- state  out  3  current FSM state, for debug/display.

Behaviour:
- All outputs are registered.
- Reset (async, rst=1) values: state=IDLE, lives=LIVES_INIT, hit_id=3, play_en=0, respawn=0, game_over=0, freeze counter=0.
- State encoding: IDLE=0, PLAY=1, HIT=2, RESPAWN=3, OVER=4.
- Contact logic (combinational, per ghost i):
  - dx = |pac_x - gi_x| in 10-bit unsigned; dy = |pac_y - gi_y| in 9-bit unsigned.
  - Compute both differences without wrap: subtract smaller from larger.
  - contact_i = (dx < HIT_DIST) && (dy < HIT_DIST).
- IDLE: start=1 → lives<=LIVES_INIT, go RESPAWN. A tick in IDLE is ignored.
- PLAY:
  - play_en=1.
  - Contacts are sampled only on cycles with tick=1.
  - If tick && any contact_i: hit_id <= lowest i in contact; lives <= lives-1 (saturates at 0); freeze counter <= FREEZE_TICKS-1; go HIT.
  - Latency: catch is visible (state=HIT, play_en=0) on the cycle after the sampling tick.
- HIT:
  - play_en=0.
  - On each tick: if counter==0, go OVER when lives==0, else go RESPAWN; otherwise counter decrements.
  - Net dwell is exactly FREEZE_TICKS ticks.
- RESPAWN: respawn=1 for exactly this one cycle, hit_id <= 3, go PLAY unconditionally.
- OVER:
  - game_over=1, play_en=0, hit_id holds.
  - start=1 → lives<=LIVES_INIT, game_over<=0, go RESPAWN.
- start is ignored in PLAY, HIT and RESPAWN.
- Boundary rules:
  - Simultaneous contacts from several ghosts on one tick cost one life only; the lowest index is reported.
  - There is no post-respawn grace period. A contact present on the first PLAY tick after respawn counts.
  - Positions are not filtered; movers must have reloaded positions by then.
  - tick and start in the same cycle in IDLE/OVER: start wins and tick is ignored.
  - An illegal state (5-7) returns to IDLE on the next clk.
  - rst asserted mid-HIT or mid-RESPAWN aborts immediately to the reset values; no pending respawn pulse is emitted.

Test Plan:
- Reset, then start=1 for 1 cycle → next cycle state=RESPAWN, respawn=1; following cycle state=PLAY, play_en=1, lives=3, hit_id=3.
- PLAY with pac=(100,100), g1=(111,89), tick → next cycle state=HIT, hit_id=1, lives=2, play_en=0. Repeat with g1=(112,100) → no catch (dx=12 not < 12).
- pac=(5,5), g0=(0,0) (reversed-order subtraction, no wrap), plus g2 also overlapping on the same tick → hit_id=0, lives drops by exactly 1.
- After a catch with lives=2: HIT lasts exactly 60 ticks, then a 1-cycle respawn pulse, then PLAY. Ticks 1-59 keep state=HIT.
- Three catches from lives=3 → after the third HIT dwell, state=OVER, game_over=1, lives=0, no respawn pulse. Then start → RESPAWN, lives=3, game_over=0.
- Assert rst for 1 cycle during HIT counter=30 → immediate IDLE, lives=3, hit_id=3, play_en=0. A tick while in IDLE causes no change.
